// File: rtl/snn_encoder_pkg.sv
// Shared definitions for the rate-coding spike encoder.
// Holds the FSM state type, LFSR constants and the per-lane seed/step helpers.
package snn_encoder_pkg;

    typedef enum logic {
        ENC_IDLE = 1'b0,
        ENC_RUN  = 1'b1
    } enc_state_e;

    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam logic [15:0] SEED_STRIDE = 16'h9E37;

    // An all-zero state would lock a Galois LFSR, so a zero seed is replaced by 1.
    function automatic logic [15:0] lane_seed(input logic [15:0] base, input logic [15:0] idx);
        logic [15:0] seed;
        seed = base ^ (idx * SEED_STRIDE);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/spike_rate_encoder_lfsr16.sv
// 16-bit Galois LFSR, one per encoder lane.
// Holds its state when en is low; only reset restores the seed.
module lfsr16
    import snn_encoder_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = en ? lfsr_next(state_q) : state_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coding front end: turns a latched intensity vector into Bernoulli spike
// trains for NUM_TIMESTEPS beats, one independent LFSR per lane.
module spike_rate_encoder
    import snn_encoder_pkg::*;
#(
    parameter int unsigned NUM_INPUTS      = 1,
    parameter int unsigned INTENSITY_WIDTH = 8,
    parameter int unsigned LFSR_WIDTH      = 16,
    parameter int unsigned NUM_TIMESTEPS   = 100,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NUM_INPUTS*INTENSITY_WIDTH-1:0] intensity,
    output logic [NUM_INPUTS-1:0]                 spike_out,
    output logic                                  spike_valid,
    output logic                                  window_done
);

    localparam int unsigned CNT_W = $clog2(NUM_TIMESTEPS + 1);
    localparam logic [LFSR_WIDTH-1:0] LOW_MASK =
        LFSR_WIDTH'((64'd1 << INTENSITY_WIDTH) - 64'd1);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(NUM_TIMESTEPS - 1);

    enc_state_e                            state_q, state_d;
    logic [CNT_W-1:0]                      count_q, count_d;
    logic [NUM_INPUTS*INTENSITY_WIDTH-1:0] latched_q, latched_d;
    logic [NUM_INPUTS-1:0]                 spike_q, spike_d;
    logic                                  spike_valid_q, spike_valid_d;
    logic                                  done_q, done_d;

    logic                  run_en;
    logic [LFSR_WIDTH-1:0] lfsr_state [NUM_INPUTS];
    logic [NUM_INPUTS-1:0] hit;

    assign run_en = (state_q == ENC_RUN);

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
        lfsr16 #(
            .SEED(lane_seed(LFSR_SEED, 16'(g)))
        ) u_lfsr (
            .clk  (clk),
            .rst  (rst),
            .en   (run_en),
            .state(lfsr_state[g])
        );
    end

    // Compare against the post-advance LFSR value so the registered spike and
    // the LFSR step land on the same edge.
    always_comb begin
        logic [LFSR_WIDTH-1:0] nxt;
        logic [LFSR_WIDTH-1:0] lane_val;
        hit = '0;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            nxt      = lfsr_next(lfsr_state[i]);
            lane_val = LFSR_WIDTH'(latched_q[i*INTENSITY_WIDTH +: INTENSITY_WIDTH]);
            hit[i]   = lane_val > (nxt & LOW_MASK);
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        latched_d     = latched_q;
        spike_d       = '0;
        spike_valid_d = 1'b0;
        done_d        = 1'b0;
        in_ready      = (state_q == ENC_IDLE);
        case (state_q)
            ENC_IDLE: begin
                if (in_valid) begin
                    latched_d = intensity;
                    count_d   = '0;
                    state_d   = ENC_RUN;
                end
            end
            ENC_RUN: begin
                spike_d       = hit;
                spike_valid_d = 1'b1;
                count_d       = count_q + CNT_W'(1);
                if (count_q == LAST_COUNT) begin
                    done_d  = 1'b1;
                    state_d = ENC_IDLE;
                end
            end
            default: state_d = ENC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ENC_IDLE;
            count_q       <= '0;
            latched_q     <= '0;
            spike_q       <= '0;
            spike_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            latched_q     <= latched_d;
            spike_q       <= spike_d;
            spike_valid_q <= spike_valid_d;
            done_q        <= done_d;
        end
    end

    assign spike_out   = spike_q;
    assign spike_valid = spike_valid_q;
    assign window_done = done_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed self-checking bench for spike_rate_encoder (2 lanes, 100 timesteps)
// with an independent LFSR reference model.
module tb_spike_rate_encoder;

    localparam int N = 100;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] intensity;
    logic [1:0]  spike_out;
    logic        spike_valid;
    logic        window_done;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_lfsr [2];

    spike_rate_encoder #(
        .NUM_INPUTS     (2),
        .INTENSITY_WIDTH(8),
        .LFSR_WIDTH     (16),
        .NUM_TIMESTEPS  (N),
        .LFSR_SEED      (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .intensity  (intensity),
        .spike_out  (spike_out),
        .spike_valid(spike_valid),
        .window_done(window_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [15:0] m_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    task automatic model_reset();
        m_lfsr[0] = 16'hACE1;
        m_lfsr[1] = 16'hACE1 ^ 16'h9E37;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the last beat.
    task automatic apply_stimulus(input string name, input logic [15:0] vec, input bit hold,
                                  input int abort_at, output int c0, output int c1,
                                  output logic [N-1:0] s0, output logic [N-1:0] s1);
        logic [1:0] exp_spk;
        c0 = 0;
        c1 = 0;
        s0 = '0;
        s1 = '0;
        intensity = vec;
        in_valid  = 1'b1;
        check_output({name, "_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        check_output({name, "_lat_valid"}, 32'(spike_valid), 32'd0);
        check_output({name, "_lat_ready"}, 32'(in_ready), 32'd0);
        if (hold) intensity = 16'($urandom);
        else      in_valid  = 1'b0;
        for (int k = 1; k <= N; k++) begin
            @(negedge clk);
            m_lfsr[0] = m_step(m_lfsr[0]);
            m_lfsr[1] = m_step(m_lfsr[1]);
            exp_spk[0] = vec[7:0]  > m_lfsr[0][7:0];
            exp_spk[1] = vec[15:8] > m_lfsr[1][7:0];
            check_output($sformatf("%s_b%0d_valid", name, k), 32'(spike_valid), 32'd1);
            check_output($sformatf("%s_b%0d_spike", name, k), 32'(spike_out), 32'(exp_spk));
            check_output($sformatf("%s_b%0d_done", name, k), 32'(window_done), 32'(k == N));
            check_output($sformatf("%s_b%0d_ready", name, k), 32'(in_ready), 32'(k == N));
            c0 += int'(spike_out[0]);
            c1 += int'(spike_out[1]);
            s0[k-1] = spike_out[0];
            s1[k-1] = spike_out[1];
            if (k == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check_output({name, "_abort_valid"}, 32'(spike_valid), 32'd0);
                check_output({name, "_abort_spike"}, 32'(spike_out), 32'd0);
                check_output({name, "_abort_done"}, 32'(window_done), 32'd0);
                model_reset();
                break;
            end
            if (hold && k < N) intensity = 16'($urandom);
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_valid"}, 32'(spike_valid), 32'd0);
        check_output({tag, "_spike"}, 32'(spike_out), 32'd0);
        check_output({tag, "_done"}, 32'(window_done), 32'd0);
        check_output({tag, "_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int c0, c1;
        logic [N-1:0] s0, s1, w2_0, w2_1, w5_0, w5_1;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        intensity = 16'h0000;
        model_reset();
        #3;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
        end

        // Lane 0 at 0, lane 1 at full scale.
        apply_stimulus("w1", 16'hFF00, 1'b0, 0, c0, c1, s0, s1);
        check_output("w1_lane0_count", 32'(c0), 32'd0);
        check_output("w1_lane1_ge95", 32'(c1 >= 95), 32'd1);
        @(negedge clk);
        check_idle("w1_post");

        // Back-to-back windows with in_valid held and junk offered during RUN.
        apply_stimulus("w2", 16'h8080, 1'b1, 0, c0, c1, w2_0, w2_1);
        check_output("w2_lane0_range", 32'(c0 >= 35 && c0 <= 65), 32'd1);
        apply_stimulus("w3", 16'h8080, 1'b1, 0, c0, c1, s0, s1);
        check_output("w3_continues_lfsr", 32'((s0 != w2_0) || (s1 != w2_1)), 32'd1);
        apply_stimulus("w4", 16'h40C8, 1'b0, 0, c0, c1, s0, s1);
        @(negedge clk);
        check_idle("w4_post");

        // Fresh reset, then abort a window mid-way with an async reset.
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus("w5", 16'hC8C8, 1'b0, 50, c0, c1, w5_0, w5_1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output($sformatf("rst_hold%0d_done", i), 32'(window_done), 32'd0);
            check_output($sformatf("rst_hold%0d_valid", i), 32'(spike_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_abort");
        apply_stimulus("w6", 16'hC8C8, 1'b0, 0, c0, c1, s0, s1);
        check_output("w6_repeat_lane0", 32'(s0[49:0] == w5_0[49:0]), 32'd1);
        check_output("w6_repeat_lane1", 32'(s1[49:0] == w5_1[49:0]), 32'd1);
        @(negedge clk);
        check_idle("w6_post");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_rate_encoder.md
# spike_rate_encoder

Rate-coding front end of the SNN datapath: accepts one vector of pixel intensities per presentation window and converts it into Bernoulli spike trains, one bit per input lane per timestep. Its `spike_out` bus drives the `spike_in` port of the spiking network directly, one lane per network input. Each lane owns an independent LFSR, so spike trains are uncorrelated across lanes and bit-exact reproducible from reset.

## Interface
Parameters:
- `NUM_INPUTS`, 1, number of input lanes; equals the network's `NUM_INPUTS`.
- `INTENSITY_WIDTH`, 8, bits per intensity value; must be ≤ `LFSR_WIDTH`.
- `LFSR_WIDTH`, 16, width of each lane LFSR; fixed at 16 in this revision.
- `NUM_TIMESTEPS`, 100, timesteps per presentation window; must be ≥ 1.
- `LFSR_SEED`, 16'hACE1, base seed; must be nonzero.

Ports:
- `clk`, input, 1, single clock for the whole block.
- `rst`, input, 1, reset, asynchronous, active-low.
- `in_valid`, input, 1, intensity vector offered.
- `in_ready`, output, 1, encoder can accept a vector.
- `intensity`, input, `NUM_INPUTS*INTENSITY_WIDTH`, lane i occupies bits `[i*INTENSITY_WIDTH +: INTENSITY_WIDTH]`; unsigned.
- `spike_out`, output, `NUM_INPUTS`, one spike bit per lane for the current timestep.
- `spike_valid`, output, 1, `spike_out` carries a timestep of the current window.
- `window_done`, output, 1, one-cycle pulse on the last timestep of a window.

## Operation
- FSM has two states, IDLE and RUN.
  - IDLE: `in_ready`=1. On `in_valid && in_ready` at an edge, latch `intensity`, clear the step counter, and go to RUN.
  - RUN: `in_ready`=0; `in_valid` is ignored and `intensity` is not sampled.
- At each RUN edge:
  - Every lane LFSR advances one step.
  - Lane i registers `spike_out[i] = (latched_intensity[i] > lfsr_i_next[INTENSITY_WIDTH-1:0])`, a strict unsigned compare against the post-advance state.
  - `spike_valid` is registered 1.
  - The step counter increments.
- When the counter reaches `NUM_TIMESTEPS`:
  - `window_done` is registered 1 on the same edge as the final `spike_valid` beat.
  - The next state is IDLE.
- Boundary behaviour:
  - Intensity 0 never spikes.
  - Intensity `2^INTENSITY_WIDTH-1` spikes unless the LFSR low bits are all ones.
- LFSR:
  - Galois form, polynomial x^16+x^14+x^13+x^11+1 (tap mask 16'hB400).
  - Advances only in RUN.
  - Is not reseeded between windows; only reset reseeds it.
- Lane seed: `LFSR_SEED ^ (i * 16'h9E37)`, truncated to 16 bits. If the result is 0, the seed is 16'h0001.
- Counter width: `$clog2(NUM_TIMESTEPS+1)`. There is no wrap-around within a window.

## Timing
- Reset (asynchronous assert, synchronous release) puts the block in:
  - state IDLE, `in_ready`=1;
  - `spike_out`=0, `spike_valid`=0, `window_done`=0;
  - counter 0, LFSRs = lane seeds, latched intensities 0.
- Acceptance at edge E0 produces `spike_valid`=1 after edges E1..E_N (N=`NUM_TIMESTEPS`), exactly N beats with no gaps. `window_done` is 1 only after E_N.
- After E_N, `spike_out` and `spike_valid` return to 0 and `in_ready` is 1.
- Back-to-back: the next acceptance can occur at E_{N+1}, giving its first beat after E_{N+2}. There is a one-cycle bubble between windows.
- `in_ready` is decoded from the registered state and has no combinational path from `in_valid`.
- `rst` asserted mid-window aborts immediately: the partial window is discarded and no `window_done` is produced.
- `in_valid` held high across a whole window: exactly one vector is accepted per IDLE cycle.

## Structure
- Shared package `snn_encoder_pkg` holds:
  - the state enum (`ENC_IDLE`, `ENC_RUN`);
  - `LFSR_TAPS` = 16'hB400;
  - the seed constant 16'h9E37;
  - function `lane_seed(base, idx)`, including the zero substitution.
- Sub-module `lfsr16`: ports `clk`, `rst`, `en`, parameter `SEED`, output `state`. It is instantiated `NUM_INPUTS` times via generate.
- The top level holds the FSM, the counter, the intensity latch and the compare/register stage.

## Test plan
- Reset then idle, `NUM_TIMESTEPS`=100: `in_ready`=1, `spike_out`=0, `spike_valid`=0, `window_done`=0 for 20 cycles.
- `NUM_INPUTS`=2, intensities {0, 255}: exactly 100 `spike_valid` beats.
  - Lane 0 has 0 spikes.
  - Lane 1 has ≥95 spikes and matches a reference model bit-exactly.
  - `window_done` appears once, on beat 100.
- Intensity 128, single lane: the spike count matches the reference model exactly and lies between 35 and 65. A second window continues the LFSR sequence rather than repeating window 1.
- `in_valid` held high continuously with a new vector each cycle: windows start on every acceptance edge, with one bubble cycle between beats 100 and the next beat 1. Vectors offered during RUN are not captured.
- Assert `rst` at beat 50:
  - Outputs go to 0 asynchronously and `window_done` is never seen.
  - After release, a window with intensity 200 reproduces the post-reset spike sequence bit-exactly.
